// File: rtl/instr_fetch_reg_pkg.sv
// Shared definitions for the instruction fetch register: FSM state encoding,
// opcode constants used by the immediate-extend decision, and extend-type values.
package instr_fetch_reg_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FETCH = 1'b1
   } fetch_state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ANDI  = 6'h0c;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_XORI  = 6'h0e;
   localparam logic [5:0] OP_LUI   = 6'h0f;

   localparam logic EXT_ZERO = 1'b0;
   localparam logic EXT_SIGN = 1'b1;

   // Logical immediates and lui zero-extend. R-type (op 0) carries no
   // immediate, so it reports zero-extend, which also makes the nop reset
   // value of ir present ext_type=0.
   function automatic logic ext_type_of(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: return EXT_ZERO;
         default:                                   return EXT_SIGN;
      endcase
   endfunction

   // Wait counter only needs to reach WAIT_LIMIT-1.
   function automatic int unsigned cnt_width(input int unsigned limit);
      return (limit < 2) ? 1 : $clog2(limit);
   endfunction

endpackage

// File: rtl/instr_fetch_reg_if.sv
// Instruction-memory request/ready bus between the fetch unit (master)
// and instruction memory (slave).
interface instr_fetch_reg_if #(
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                  imem_req;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic                  imem_ready;
   logic [31:0]           imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );
endinterface

// File: rtl/instr_fetch_reg_ir_fields.sv
// Purely combinational split of the instruction register into its decoded
// fields, plus the extend-type select for the immediate extender.
module instr_fetch_reg_ir_fields
   import instr_fetch_reg_pkg::*;
(
   input  logic [31:0] ir,
   output logic [5:0]  op,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [5:0]  funct,
   output logic [15:0] imm16,
   output logic [25:0] jidx,
   output logic        ext_type
);

   // Field extraction and extend-type derivation
   always_comb begin
      op       = ir[31:26];
      rs       = ir[25:21];
      rt       = ir[20:16];
      rd       = ir[15:11];
      shamt    = ir[10:6];
      funct    = ir[5:0];
      imm16    = ir[15:0];
      jidx     = ir[25:0];
      ext_type = ext_type_of(ir[31:26]);
   end

endmodule

// File: rtl/instr_fetch_reg.sv
// Instruction register and fetch sequencer. A one-cycle fetch_start launches a
// single req/ready transaction to instruction memory; the returned word is
// latched into ir and held until the next completed fetch.
// Optional build macro: IFETCH_ALIGN_CHECK_EN -- when defined, a fetch_start
// with a non word-aligned pc is rejected with a fetch_err pulse.
module instr_fetch_reg
   import instr_fetch_reg_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned WAIT_LIMIT = 15,
   parameter logic [31:0] RESET_IR   = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fetch_start,
   input  logic                  ir_clear,
   input  logic [ADDR_WIDTH-1:0] pc,
   instr_fetch_reg_if.master     imem,
   output logic [31:0]           ir,
   output logic [5:0]            op,
   output logic [4:0]            rs,
   output logic [4:0]            rt,
   output logic [4:0]            rd,
   output logic [4:0]            shamt,
   output logic [5:0]            funct,
   output logic [15:0]           imm16,
   output logic [25:0]           jidx,
   output logic                  ext_type,
   output logic                  ir_valid,
   output logic                  busy,
   output logic                  fetch_done,
   output logic                  fetch_err
);

   localparam int unsigned CNT_W = cnt_width(WAIT_LIMIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

   fetch_state_e          state_q, state_d;
   logic [31:0]           ir_q, ir_d;
   logic                  ir_valid_q, ir_valid_d;
   logic                  imem_req_q, imem_req_d;
   logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
   logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
   logic                  busy_q, busy_d;
   logic                  fetch_done_q, fetch_done_d;
   logic                  fetch_err_q, fetch_err_d;

   logic                  misaligned;
   logic                  timeout_hit;

`ifdef IFETCH_ALIGN_CHECK_EN
   assign misaligned = (pc[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   // WAIT_LIMIT of zero means wait forever for imem_ready.
   assign timeout_hit = (WAIT_LIMIT != 0) && (wait_cnt_q == CNT_LAST);

   // State and output registers; reset drops imem_req immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         ir_q         <= RESET_IR;
         ir_valid_q   <= 1'b0;
         imem_req_q   <= 1'b0;
         imem_addr_q  <= '0;
         wait_cnt_q   <= '0;
         busy_q       <= 1'b0;
         fetch_done_q <= 1'b0;
         fetch_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         ir_q         <= ir_d;
         ir_valid_q   <= ir_valid_d;
         imem_req_q   <= imem_req_d;
         imem_addr_q  <= imem_addr_d;
         wait_cnt_q   <= wait_cnt_d;
         busy_q       <= busy_d;
         fetch_done_q <= fetch_done_d;
         fetch_err_q  <= fetch_err_d;
      end
   end

   // Next-state: launch from IDLE, finish on ready or timeout; clear overrides all
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (fetch_start && !misaligned) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (imem.imem_ready || timeout_hit) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (ir_clear) state_d = ST_IDLE;
   end

   // Register next values: capture address, latch data, count waits, pulse done/err
   always_comb begin
      ir_d         = ir_q;
      ir_valid_d   = ir_valid_q;
      imem_addr_d  = imem_addr_q;
      wait_cnt_d   = wait_cnt_q;
      fetch_done_d = 1'b0;
      fetch_err_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fetch_start) begin
               if (misaligned) begin
                  fetch_err_d = 1'b1;
               end else begin
                  imem_addr_d = pc;
                  ir_valid_d  = 1'b0;
                  wait_cnt_d  = '0;
               end
            end
         end
         ST_FETCH: begin
            if (imem.imem_ready) begin
               ir_d         = imem.imem_rdata;
               ir_valid_d   = 1'b1;
               fetch_done_d = 1'b1;
            end else if (timeout_hit) begin
               fetch_err_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
      // A flush aborts everything in flight but leaves the last address visible.
      if (ir_clear) begin
         ir_d         = RESET_IR;
         ir_valid_d   = 1'b0;
         imem_addr_d  = imem_addr_q;
         wait_cnt_d   = '0;
         fetch_done_d = 1'b0;
         fetch_err_d  = 1'b0;
      end
      imem_req_d = (state_d == ST_FETCH);
      busy_d     = (state_d == ST_FETCH);
   end

   // Drive registered outputs
   always_comb begin
      imem.imem_req  = imem_req_q;
      imem.imem_addr = imem_addr_q;
      ir             = ir_q;
      ir_valid       = ir_valid_q;
      busy           = busy_q;
      fetch_done     = fetch_done_q;
      fetch_err      = fetch_err_q;
   end

   instr_fetch_reg_ir_fields u_ir_fields (
      .ir       (ir_q),
      .op       (op),
      .rs       (rs),
      .rt       (rt),
      .rd       (rd),
      .shamt    (shamt),
      .funct    (funct),
      .imm16    (imm16),
      .jidx     (jidx),
      .ext_type (ext_type)
   );

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Directed bench for instr_fetch_reg: per-cycle vector table plus hand-written
// sequences for field decode, timeout and reset during a fetch.
// Honours IFETCH_ALIGN_CHECK_EN in its expectations.
module tb_instr_fetch_reg;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_start;
   logic        ir_clear;
   logic [31:0] pc;
   logic [31:0] ir;
   logic [5:0]  op;
   logic [4:0]  rs, rt, rd, shamt;
   logic [5:0]  funct;
   logic [15:0] imm16;
   logic [25:0] jidx;
   logic        ext_type, ir_valid, busy, fetch_done, fetch_err;

   int errors = 0;
   int checks = 0;

   instr_fetch_reg_if #(.ADDR_WIDTH(32)) imem_if_i ();

   instr_fetch_reg #(
      .ADDR_WIDTH (32),
      .WAIT_LIMIT (4),
      .RESET_IR   (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .fetch_start (fetch_start),
      .ir_clear    (ir_clear),
      .pc          (pc),
      .imem        (imem_if_i.master),
      .ir          (ir),
      .op          (op),
      .rs          (rs),
      .rt          (rt),
      .rd          (rd),
      .shamt       (shamt),
      .funct       (funct),
      .imm16       (imm16),
      .jidx        (jidx),
      .ext_type    (ext_type),
      .ir_valid    (ir_valid),
      .busy        (busy),
      .fetch_done  (fetch_done),
      .fetch_err   (fetch_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        fs;
      logic        clr;
      logic [31:0] pc;
      logic        rdy;
      logic [31:0] rdata;
      logic        req;
      logic [31:0] addr;
      logic [31:0] ir;
      logic        valid;
      logic        done;
      logic        err;
      logic        busy;
      logic        ext;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic fs, input logic clr, input logic [31:0] p,
                        input logic rdy, input logic [31:0] rdata);
      fetch_start          = fs;
      ir_clear             = clr;
      pc                   = p;
      imem_if_i.imem_ready = rdy;
      imem_if_i.imem_rdata = rdata;
   endtask

   task automatic chk_state(input string tag, input logic req, input logic [31:0] addr,
                            input logic [31:0] irx, input logic valid, input logic done,
                            input logic err, input logic bsy, input logic ext);
      chk({tag, ".imem_req"},   32'(imem_if_i.imem_req),  32'(req));
      chk({tag, ".imem_addr"},  imem_if_i.imem_addr,      addr);
      chk({tag, ".ir"},         ir,                       irx);
      chk({tag, ".ir_valid"},   32'(ir_valid),            32'(valid));
      chk({tag, ".fetch_done"}, 32'(fetch_done),          32'(done));
      chk({tag, ".fetch_err"},  32'(fetch_err),           32'(err));
      chk({tag, ".busy"},       32'(busy),                32'(bsy));
      chk({tag, ".ext_type"},   32'(ext_type),            32'(ext));
   endtask

   initial begin
      // Each row: inputs held for one clock, then outputs after that edge.
      //                fs clr pc         rdy rdata          req addr       ir             vld dn er bsy ext
      vecs.push_back('{1'b0,1'b0,32'h0,  1'b0,32'h0,         1'b0,32'h0,  32'h0,         1'b0,1'b0,1'b0,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b0,32'h40, 1'b0,32'h0,         1'b1,32'h40, 32'h0,         1'b0,1'b0,1'b0,1'b1,1'b0});
      vecs.push_back('{1'b0,1'b0,32'h0,  1'b1,32'h2008FFFF,  1'b0,32'h40, 32'h2008FFFF,  1'b1,1'b1,1'b0,1'b0,1'b1});
      vecs.push_back('{1'b0,1'b0,32'h0,  1'b1,32'hDEADBEEF,  1'b0,32'h40, 32'h2008FFFF,  1'b1,1'b0,1'b0,1'b0,1'b1});
      vecs.push_back('{1'b1,1'b0,32'h80, 1'b0,32'h0,         1'b1,32'h80, 32'h2008FFFF,  1'b0,1'b0,1'b0,1'b1,1'b1});
      vecs.push_back('{1'b0,1'b0,32'h0,  1'b0,32'h0,         1'b1,32'h80, 32'h2008FFFF,  1'b0,1'b0,1'b0,1'b1,1'b1});
      vecs.push_back('{1'b1,1'b0,32'h100,1'b0,32'h0,         1'b1,32'h80, 32'h2008FFFF,  1'b0,1'b0,1'b0,1'b1,1'b1});
      vecs.push_back('{1'b0,1'b0,32'h0,  1'b0,32'h0,         1'b1,32'h80, 32'h2008FFFF,  1'b0,1'b0,1'b0,1'b1,1'b1});
      vecs.push_back('{1'b1,1'b0,32'h500,1'b1,32'h350800FF,  1'b0,32'h80, 32'h350800FF,  1'b1,1'b1,1'b0,1'b0,1'b0});
      vecs.push_back('{1'b0,1'b0,32'h0,  1'b0,32'h0,         1'b0,32'h80, 32'h350800FF,  1'b1,1'b0,1'b0,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b0,32'h200,1'b0,32'h0,         1'b1,32'h200,32'h350800FF,  1'b0,1'b0,1'b0,1'b1,1'b0});
      vecs.push_back('{1'b0,1'b1,32'h0,  1'b0,32'h0,         1'b0,32'h200,32'h0,         1'b0,1'b0,1'b0,1'b0,1'b0});
      vecs.push_back('{1'b0,1'b0,32'h0,  1'b1,32'h12345678,  1'b0,32'h200,32'h0,         1'b0,1'b0,1'b0,1'b0,1'b0});
      vecs.push_back('{1'b1,1'b1,32'h300,1'b0,32'h0,         1'b0,32'h200,32'h0,         1'b0,1'b0,1'b0,1'b0,1'b0});
`ifdef IFETCH_ALIGN_CHECK_EN
      vecs.push_back('{1'b1,1'b0,32'h42, 1'b0,32'h0,         1'b0,32'h200,32'h0,         1'b0,1'b0,1'b1,1'b0,1'b0});
      vecs.push_back('{1'b0,1'b0,32'h0,  1'b1,32'h11111111,  1'b0,32'h200,32'h0,         1'b0,1'b0,1'b0,1'b0,1'b0});
`else
      vecs.push_back('{1'b1,1'b0,32'h42, 1'b0,32'h0,         1'b1,32'h42, 32'h0,         1'b0,1'b0,1'b0,1'b1,1'b0});
      vecs.push_back('{1'b0,1'b0,32'h0,  1'b1,32'h00000020,  1'b0,32'h42, 32'h00000020,  1'b1,1'b1,1'b0,1'b0,1'b0});
`endif

      reset = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      tick();
      reset = 1'b0;
      chk_state("reset", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      foreach (vecs[i]) begin
         drive(vecs[i].fs, vecs[i].clr, vecs[i].pc, vecs[i].rdy, vecs[i].rdata);
         tick();
         chk_state($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].ir,
                   vecs[i].valid, vecs[i].done, vecs[i].err, vecs[i].busy, vecs[i].ext);
      end
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();

      // lui $1, 0xABCD: zero-extended immediate
      drive(1'b1, 1'b0, 32'h10, 1'b0, 32'h0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h3C01ABCD);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("lui.done",  32'(fetch_done), 32'h1);
      chk("lui.op",    32'(op),         32'h0F);
      chk("lui.rt",    32'(rt),         32'h1);
      chk("lui.imm16", 32'(imm16),      32'hABCD);
      chk("lui.ext",   32'(ext_type),   32'h0);

      // sll $8, $10, 3: R-type fields
      tick();
      drive(1'b1, 1'b0, 32'h14, 1'b0, 32'h0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h000A40C0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("sll.op",    32'(op),       32'h0);
      chk("sll.rs",    32'(rs),       32'h0);
      chk("sll.rt",    32'(rt),       32'd10);
      chk("sll.rd",    32'(rd),       32'd8);
      chk("sll.shamt", 32'(shamt),    32'd3);
      chk("sll.funct", 32'(funct),    32'h0);
      chk("sll.jidx",  32'(jidx),     32'h00A40C0);
      chk("sll.ext",   32'(ext_type), 32'h0);

      // Timeout: WAIT_LIMIT=4 FETCH cycles with no ready
      tick();
      drive(1'b1, 1'b0, 32'h600, 1'b0, 32'h0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("to.req_c1", 32'(imem_if_i.imem_req), 32'h1);
      for (int c = 2; c <= 4; c++) begin
         tick();
         chk($sformatf("to.req_c%0d", c), 32'(imem_if_i.imem_req), 32'h1);
         chk($sformatf("to.err_c%0d", c), 32'(fetch_err),          32'h0);
      end
      tick();
      chk_state("to.expire", 1'b0, 32'h600, 32'h000A40C0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      chk("to.err_pulse", 32'(fetch_err), 32'h0);

      // Reset in the middle of a fetch drops imem_req before the next edge
      drive(1'b1, 1'b0, 32'h700, 1'b0, 32'h0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("rst.req_before", 32'(imem_if_i.imem_req), 32'h1);
      #2 reset = 1'b1;
      #1;
      chk_state("rst.async", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      reset = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFEF00D);
      tick();
      chk_state("rst.after", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
